// File: rtl/sound_request_queue.sv
// Sound-effect request queue: fixed-priority arbiter, FIFO and issue FSM for the audio SOPC PIO.
// Optional SOUND_QUEUE_PREEMPT_EN: a source-0 request while busy flushes the queue and restarts the issue.
`timescale 1ns/1ps
module sound_request_queue #(
  parameter int ID_W           = 4,
  parameter int DEPTH          = 8,
  parameter int N_SRC          = 3,
  parameter int HOLD_CYCLES    = 1024,
  parameter int TIMEOUT_CYCLES = 1 << 24
) (
  input  logic                         clk50m,
  input  logic                         reset,
  input  logic [N_SRC-1:0]             req_valid,
  input  logic [N_SRC*ID_W-1:0]        req_id,
  output logic [N_SRC-1:0]             req_ready,
  output logic [ID_W-1:0]              sound_id_out,
  output logic                         start_sound_out,
  input  logic                         sound_done,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   queue_count,
  output logic                         overflow,
  output logic                         timeout
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = $clog2(DEPTH + 1);
  localparam int MAX_WAIT = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W    = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_WAIT_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               start_q, start_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               timeout_q, timeout_d;
  logic               overflow_q, overflow_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ID_W-1:0]    mem_q [DEPTH];

  logic               full;
  logic               seen;
  logic               grant_ok;
  logic               push;
  logic               fifo_push;
  logic               pop;
  logic               flush;
  logic               preempt;
  logic [ID_W-1:0]    push_id;
  logic [ID_W-1:0]    head_id;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign head_id = mem_q[rd_ptr_q];

  // Fixed-priority grant: the first valid source (lowest index) is the only candidate.
  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    req_ready = '0;
    push_id   = '0;
    seen      = 1'b0;
    grant_ok  = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
`ifdef SOUND_QUEUE_PREEMPT_EN
      grant_ok = (k == 0) ? 1'b1 : !full;
`else
      grant_ok = !full;
`endif
      if (req_valid[k] && !seen) begin
        seen = 1'b1;
        if (grant_ok && !reset) begin
          req_ready[k] = 1'b1;
          push_id      = req_id[k*ID_W +: ID_W];
        end
      end
    end
  end

  assign push = |req_ready;

`ifdef SOUND_QUEUE_PREEMPT_EN
  assign preempt = req_ready[0] && (state_q != S_IDLE);
`else
  assign preempt = 1'b0;
`endif

  assign fifo_push = push && !preempt;

  // Issue FSM; a preempting source-0 request overrides whatever the state logic chose.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    start_d   = start_q;
    id_d      = id_q;
    timeout_d = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          id_d    = head_id;
          start_d = 1'b1;
          tmr_d   = '0;
          state_d = S_ASSERT;
        end
      end
      S_ASSERT: begin
        if (tmr_q == TMR_W'(HOLD_CYCLES - 1)) begin
          start_d = 1'b0;
          tmr_d   = '0;
          state_d = S_WAIT_DONE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (sound_done) begin
          state_d = S_IDLE;
        end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (preempt) begin
      flush   = 1'b1;
      pop     = 1'b0;
      id_d    = req_id[ID_W-1:0];
      start_d = 1'b1;
      tmr_d   = '0;
      state_d = S_ASSERT;
    end
  end

  // FIFO bookkeeping; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (full && (|req_valid));

    if (fifo_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)       rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({fifo_push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk50m) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      start_q    <= 1'b0;
      id_q       <= '0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      start_q    <= start_d;
      id_q       <= id_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: storage is not reset; the count and pointers alone decide which entries are valid.
  always_ff @(posedge clk50m) begin
    if (fifo_push) mem_q[wr_ptr_q] <= push_id;
  end

  // The strobe is gated by reset so it drops in the same cycle reset is raised.
  assign start_sound_out = start_q & ~reset;
  assign sound_id_out    = id_q;
  assign busy            = (state_q != S_IDLE);
  assign queue_count     = count_q;
  assign overflow        = overflow_q;
  assign timeout         = timeout_q;

endmodule
